// File: rtl/s_axis_sample_rx.sv
// s_axis_sample_rx: AXI-Stream slave receiver for 12-bit ADC samples.
// Accepted beats are buffered in a first-word-fall-through FIFO and handed
// to a local consumer through rx_valid/rd_en. Frame boundaries are tracked
// from tlast and malformed beats (nonzero upper nibble) raise fmt_err.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            1 = accept beats, 0 = hold s_axis_tready low
//   s_axis_tdata      16-bit payload, [11:0] sample, [15:12] must be zero
//   s_axis_tvalid     upstream beat valid
//   s_axis_tlast      last beat of frame
//   s_axis_tready     receiver can accept a beat (registered)
//   rd_en             consumer pop request
//   rx_data, rx_last  head entry of the FIFO
//   rx_valid          FIFO not empty
//   frame_done        one-cycle pulse after a frame completes
//   frame_len         beat count of the most recent completed frame
//   in_frame          a frame is partially received
//   clr_err           clears fmt_err (a coincident new error wins)
//   fmt_err           sticky format-error flag
module s_axis_sample_rx #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [15:0]      s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  input  logic             rd_en,
  output logic [11:0]      rx_data,
  output logic             rx_last,
  output logic             rx_valid,
  output logic             frame_done,
  output logic [LEN_W-1:0] frame_len,
  output logic             in_frame,
  input  logic             clr_err,
  output logic             fmt_err
);

  localparam int unsigned DATA_W = 12;
  localparam int unsigned ENT_W  = DATA_W + 1;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic {IDLE = 1'b0, IN_FRAME = 1'b1} state_t;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [ENT_W-1:0] wr_entry, head_nxt;
  logic             accept, pop;
  state_t           state;
  logic [LEN_W-1:0] beat_cnt, beat_inc;

  assign accept   = s_axis_tvalid & s_axis_tready;
  assign pop      = rd_en & rx_valid;
  assign wr_entry = {s_axis_tlast, s_axis_tdata[DATA_W-1:0]};
  assign in_frame = (state == IN_FRAME);

  // Next read pointer, occupancy and head entry after this edge.
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (pop) rd_ptr_nxt = rd_ptr + PTR_W'(1);
    if (accept && !pop)      count_nxt = count + CNT_W'(1);
    else if (pop && !accept) count_nxt = count - CNT_W'(1);
    // A beat written this edge into the slot that becomes the head bypasses mem.
    if (accept && (wr_ptr == rd_ptr_nxt)) head_nxt = wr_entry;
    else                                  head_nxt = mem[rd_ptr_nxt];
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wr_entry;
  end

  // Pointers, occupancy, ready and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      s_axis_tready <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_last       <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr        <= rd_ptr_nxt;
      count         <= count_nxt;
      s_axis_tready <= enable & (count_nxt != CNT_W'(DEPTH));
      rx_valid      <= (count_nxt != '0);
      if (count_nxt != '0) begin
        rx_data <= head_nxt[DATA_W-1:0];
        rx_last <= head_nxt[DATA_W];
      end
    end
  end

  assign beat_inc = (beat_cnt == {LEN_W{1'b1}}) ? beat_cnt : beat_cnt + LEN_W'(1);

  // Frame tracker: counts beats of the open frame and reports on tlast.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      frame_len  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept & s_axis_tlast;
      case (state)
        IDLE: begin
          if (accept) begin
            if (s_axis_tlast) begin
              frame_len <= LEN_W'(1);
            end else begin
              state    <= IN_FRAME;
              beat_cnt <= LEN_W'(1);
            end
          end
        end
        IN_FRAME: begin
          if (accept) begin
            if (s_axis_tlast) begin
              frame_len <= beat_inc;
              beat_cnt  <= '0;
              state     <= IDLE;
            end else begin
              beat_cnt <= beat_inc;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky format error; a new error beat beats a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                fmt_err <= 1'b0;
    else if (accept && (s_axis_tdata[15:12] != 4'h0)) fmt_err <= 1'b1;
    else if (clr_err)                          fmt_err <= 1'b0;
  end

endmodule

// File: tb/tb_s_axis_sample_rx.sv
module tb_s_axis_sample_rx;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [15:0]      s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tlast;
  logic             s_axis_tready;
  logic             rd_en;
  logic [11:0]      rx_data;
  logic             rx_last;
  logic             rx_valid;
  logic             frame_done;
  logic [LEN_W-1:0] frame_len;
  logic             in_frame;
  logic             clr_err;
  logic             fmt_err;

  s_axis_sample_rx #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .rd_en(rd_en), .rx_data(rx_data), .rx_last(rx_last), .rx_valid(rx_valid),
    .frame_done(frame_done), .frame_len(frame_len), .in_frame(in_frame),
    .clr_err(clr_err), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {tready, valid, data, last, done, len, in_frame, err}.
  logic [25:0] dut_vec;
  assign dut_vec = {s_axis_tready, rx_valid, rx_data, rx_last, frame_done,
                    frame_len, in_frame, fmt_err};

  function automatic logic [25:0] pk(input bit rdy, input bit v, input logic [11:0] d,
                                     input bit l, input bit dn, input logic [7:0] len,
                                     input bit inf, input bit e);
    return {rdy, v, d, l, dn, len, inf, e};
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [25:0] act, input logic [25:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural reference: a queue of stored beats plus frame bookkeeping.
  logic [12:0] mq[$];
  bit          m_rdy, m_last, m_done, m_inf, m_err;
  logic [11:0] m_data;
  int          m_cnt, m_len;

  function automatic void model_reset();
    mq.delete();
    m_rdy = 0; m_last = 0; m_done = 0; m_inf = 0; m_err = 0;
    m_data = '0; m_cnt = 0; m_len = 0;
  endfunction

  function automatic logic [25:0] model_vec();
    return pk(m_rdy, mq.size() > 0, m_data, m_last, m_done, 8'(m_len), m_inf, m_err);
  endfunction

  // One clock cycle: drive inputs, advance model, compare after the edge.
  task automatic cyc(input bit en, input bit tv, input logic [15:0] d,
                     input bit l, input bit rd, input bit clr);
    bit acc, pop;
    enable = en; s_axis_tvalid = tv; s_axis_tdata = d; s_axis_tlast = l;
    rd_en = rd; clr_err = clr;
    acc = tv && m_rdy;
    pop = rd && (mq.size() > 0);
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back({l, d[11:0]});
    if (mq.size() > 0) {m_last, m_data} = mq[0];
    m_done = acc && l;
    if (acc) begin
      if (l) begin
        m_len = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
        m_cnt = 0;
        m_inf = 0;
      end else begin
        m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
        m_inf = 1;
      end
    end
    if (acc && d[15:12] != 4'h0) m_err = 1;
    else if (clr) m_err = 0;
    m_rdy = en && (mq.size() < DEPTH);
    #1;
    chk("cycle", dut_vec, model_vec());
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic do_reset(input string nm);
    enable = 0; rd_en = 0; clr_err = 0;
    rst_n = 0;
    #1;
    chk(nm, dut_vec, 26'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk({nm, "_release"}, dut_vec, model_vec());
  endtask

  typedef struct {
    bit          en, tv;
    logic [15:0] d;
    bit          l, rd, clr;
    logic [25:0] exp;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sent;
    rst_n = 1; enable = 0; s_axis_tvalid = 0; s_axis_tdata = '0;
    s_axis_tlast = 0; rd_en = 0; clr_err = 0;
    model_reset();
    #2;
    do_reset("reset");

    // Basic frame, single-beat frames, format error handling, enable gating.
    tbl[0]  = '{1, 0, 16'h0000, 0, 1, 0, pk(1, 0, 12'h000, 0, 0, 8'd0, 0, 0)};
    tbl[1]  = '{1, 1, 16'h0123, 0, 1, 0, pk(1, 1, 12'h123, 0, 0, 8'd0, 1, 0)};
    tbl[2]  = '{1, 1, 16'h0456, 0, 1, 0, pk(1, 1, 12'h456, 0, 0, 8'd0, 1, 0)};
    tbl[3]  = '{1, 1, 16'h0789, 1, 1, 0, pk(1, 1, 12'h789, 1, 1, 8'd3, 0, 0)};
    tbl[4]  = '{1, 0, 16'h0000, 0, 1, 0, pk(1, 0, 12'h789, 1, 0, 8'd3, 0, 0)};
    tbl[5]  = '{1, 1, 16'h0AAA, 1, 1, 0, pk(1, 1, 12'hAAA, 1, 1, 8'd1, 0, 0)};
    tbl[6]  = '{1, 1, 16'h0BBB, 1, 1, 0, pk(1, 1, 12'hBBB, 1, 1, 8'd1, 0, 0)};
    tbl[7]  = '{1, 0, 16'h0000, 0, 1, 0, pk(1, 0, 12'hBBB, 1, 0, 8'd1, 0, 0)};
    tbl[8]  = '{1, 1, 16'hF001, 0, 0, 0, pk(1, 1, 12'h001, 0, 0, 8'd1, 1, 1)};
    tbl[9]  = '{1, 0, 16'h0000, 0, 1, 1, pk(1, 0, 12'h001, 0, 0, 8'd1, 1, 0)};
    tbl[10] = '{1, 1, 16'h1002, 1, 0, 1, pk(1, 1, 12'h002, 1, 1, 8'd2, 0, 1)};
    tbl[11] = '{0, 0, 16'h0000, 0, 1, 0, pk(0, 0, 12'h002, 1, 0, 8'd2, 0, 1)};
    tbl[12] = '{0, 1, 16'h0333, 1, 0, 0, pk(0, 0, 12'h002, 1, 0, 8'd2, 0, 1)};
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].en, tbl[i].tv, tbl[i].d, tbl[i].l, tbl[i].rd, tbl[i].clr);
      chk($sformatf("vec%0d", i), dut_vec, tbl[i].exp);
    end

    // Backpressure: fill with rd_en low, stall, pop twice, drain in order.
    cyc(1, 0, 16'h0, 0, 0, 0);
    sent = 0;
    for (int k = 0; k < 16; k++) begin
      bit will_acc;
      will_acc = (sent < 6) && m_rdy;
      cyc(1, sent < 6, 16'h0100 + 16'(sent), sent == 5, (k == 5) || (k == 6) || (k >= 9), 0);
      if (will_acc) sent++;
      if (k == 4) chk("full_no_ready", {25'h0, s_axis_tready}, 26'h0);
      if (k == 5) chk("ready_after_pop", {25'h0, s_axis_tready}, 26'h1);
      if (k == 7) chk("refilled_full", {25'h0, s_axis_tready}, 26'h0);
    end
    chk("all_sent", 26'(sent), 26'd6);

    // Long frame: beat counter saturates and the report stays at the max.
    cyc(1, 0, 16'h0, 0, 1, 0);
    for (int k = 0; k < 300; k++) cyc(1, 1, 16'h0055, 0, 1, 0);
    cyc(1, 1, 16'h0066, 1, 1, 0);
    chk("sat_len", 26'(frame_len), 26'hFF);
    cyc(1, 0, 16'h0, 0, 1, 0);

    // Reset mid-frame with two beats buffered, then a one-beat frame.
    cyc(1, 1, 16'h0011, 0, 0, 0);
    cyc(1, 1, 16'h0022, 0, 0, 0);
    do_reset("mid_frame_reset");
    cyc(1, 0, 16'h0, 0, 0, 0);
    cyc(1, 1, 16'h0033, 1, 0, 0);
    chk("len_after_reset", 26'(frame_len), 26'd1);
    chk("data_after_reset", 26'(rx_data), 26'h033);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 600; k++) begin
      logic [15:0] d;
      logic [3:0]  hi;
      hi = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      d  = {hi, 12'($urandom)};
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, d,
          $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 19) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/s_axis_sample_rx.md
Name: s_axis_sample_rx

Overview:
- AXI-Stream slave receiver: the consuming end of the 16-bit ADC-sample stream format used in the motor-control datapath.
- Payload layout: 12-bit sample in tdata[11:0], upper nibble zero, tlast marking end of frame.
- Buffers accepted beats in a small first-word-fall-through FIFO and presents them to a local consumer (PWM/current-loop logic) through a valid/pop interface.
- Tracks frame boundaries, reports frame length, and flags format violations.

Parameters:
- DEPTH, 4, FIFO depth in words; power of two, minimum 2.
- LEN_W, 8, width of the frame-length counter and report.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  1 = accept stream beats; 0 = hold s_axis_tready low.
- s_axis_tdata  input  16  stream payload; [11:0] sample, [15:12] must be 0.
- s_axis_tvalid  input  1  upstream beat valid.
- s_axis_tlast  input  1  last beat of frame.
- s_axis_tready  output  1  receiver can accept a beat.
- rd_en  input  1  consumer pop request.
- rx_data  output  12  sample at FIFO head.
- rx_last  output  1  tlast bit stored with head sample.
- rx_valid  output  1  FIFO not empty.
- frame_done  output  1  one-cycle pulse when a frame completes.
- frame_len  output  LEN_W  beat count of the most recently completed frame.
- in_frame  output  1  1 while a frame is partially received.
- clr_err  input  1  clears fmt_err.
- fmt_err  output  1  sticky format-error flag.

Behaviour:
- Reset (async, rst_n=0) clears all outputs: FIFO empty, s_axis_tready=0, rx_valid=0, rx_data=0, rx_last=0, frame_done=0, frame_len=0, in_frame=0, fmt_err=0, beat counter=0.
- Reset asserted mid-frame discards FIFO contents and the partial frame.
- s_axis_tready = enable AND NOT full.
  - Decoded from registered state only, never from s_axis_tvalid.
  - Drops the cycle after the FIFO becomes full.
- Accept condition: s_axis_tvalid AND s_axis_tready at a clock edge.
  - Writes {tlast, tdata[11:0]} at the write pointer.
  - Pointers wrap modulo DEPTH; a count register (0..DEPTH) distinguishes full from empty.
- Read side is first-word-fall-through:
  - rx_data and rx_last reflect the head entry whenever rx_valid=1.
  - Pop occurs on rd_en AND rx_valid; rd_en while empty is ignored.
  - Head data is 0 after reset and holds its last value when empty.
- Simultaneous accept and pop: count unchanged, both pointers advance.
  - At full, the accept cannot occur because tready=0; the pop frees a slot and tready rises the next cycle.
- Latency: a beat accepted at edge N is visible on rx_valid/rx_data after edge N (one cycle from acceptance to head).
- Frame FSM has two states, IDLE and IN_FRAME.
  - IDLE: accepted beat with tlast=0 -> IN_FRAME, counter=1. Accepted beat with tlast=1 -> stay IDLE, single-beat frame of length 1.
  - IN_FRAME: each accepted beat increments the counter, saturating at 2^LEN_W-1. An accepted beat with tlast=1 -> IDLE.
  - in_frame = (state == IN_FRAME).
- On every accepted tlast beat:
  - frame_len <= counter+1 (saturated), or 1 from IDLE.
  - frame_done pulses high for exactly the following cycle.
  - Counter returns to 0.
  - Back-to-back last beats give consecutive frame_done pulses.
- enable deassertion only blocks new beats.
  - The frame FSM state and counter hold.
  - FIFO contents remain drainable.
- fmt_err sets on any accepted beat with tdata[15:12] != 0.
  - The beat is still stored; only [11:0] is kept.
  - clr_err clears fmt_err. If clr_err coincides with a new error beat, set wins.
- No beat is ever dropped. Backpressure is the sole overflow mechanism.

Test Plan:
- Reset then enable=1, send 3 beats 0x0123, 0x0456, 0x0789 (last on third) with rd_en=1 -> rx_data 0x123, 0x456, 0x789 one cycle after each accept; rx_last=1 only on 0x789; frame_done one pulse; frame_len=3.
- rd_en=0, DEPTH=4, stream 6 beats continuously -> tready drops after the 4th accept; 5th beat stalls with tvalid held; after 2 pops the remaining beats are accepted in order with no loss or duplication.
- Full FIFO with simultaneous rd_en and tvalid -> pop at edge N, tready=1 at N+1, beat accepted at N+1 edge, count back to 4.
- Single-beat frames 0x0AAA(last), 0x0BBB(last) on consecutive cycles -> two consecutive frame_done pulses, frame_len=1 each, in_frame stays 0.
- Beat 0xF001 accepted -> fmt_err=1, rx_data=0x001. Pulse clr_err -> fmt_err=0. clr_err coincident with beat 0x1002 -> fmt_err remains 1.
- Assert rst_n=0 mid-frame after 2 beats with FIFO holding 2 -> all outputs 0 immediately. After release, a 1-beat frame reports frame_len=1.
